// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage datapath: stage write enables, bubble strobes,
// outstanding data-access / halt tracking and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_taken,
  output logic             pcWEN,
  output logic             if_W,
  output logic             id_W,
  output logic             ex_W,
  output logic             mem_W,
  output logic             if_flush,
  output logic             id_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;

  logic dreq;
  logic dfreeze;
  logic ifreeze;
  logic freeze;
  logic loaduse;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign dreq    = mem_dREN | mem_dWEN;
  assign dfreeze = dreq & ~dhit;
  // A pending data access masks the fetch status entirely.
  assign ifreeze = ~dreq & ~ihit;
  assign freeze  = dfreeze | ifreeze;
  assign loaduse = ex_memread && (ex_wsel != 5'd0) &&
                   ((ex_wsel == id_rs) || (ex_wsel == id_rt));

  always_comb begin
    pcWEN    = 1'b0;
    if_W     = 1'b0;
    id_W     = 1'b0;
    ex_W     = 1'b0;
    mem_W    = 1'b0;
    if_flush = 1'b0;
    id_flush = 1'b0;
    halt     = 1'b0;
    if (RST) begin
      halt = 1'b0;
    end else if (state == HALT) begin
      halt = 1'b1;
    end else if (dfreeze) begin
      pcWEN = 1'b0;
    end else if (dreq) begin
      // Data access completes: retire it, re-issue the fetch via an IF/ID bubble.
      id_W     = 1'b1;
      ex_W     = 1'b1;
      mem_W    = 1'b1;
      if_flush = 1'b1;
    end else if (ifreeze) begin
      pcWEN = 1'b0;
    end else if (ex_taken) begin
      pcWEN    = 1'b1;
      if_W     = 1'b1;
      id_W     = 1'b1;
      ex_W     = 1'b1;
      mem_W    = 1'b1;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (loaduse) begin
      id_W     = 1'b1;
      ex_W     = 1'b1;
      mem_W    = 1'b1;
      id_flush = 1'b1;
    end else begin
      pcWEN = 1'b1;
      if_W  = 1'b1;
      id_W  = 1'b1;
      ex_W  = 1'b1;
      mem_W = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (dfreeze)
            state <= DWAIT;
          else if (mem_halt && !freeze)
            state <= HALT;
        end
        DWAIT: begin
          if (dhit)
            state <= RUN;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
      if (state != HALT && !pcWEN)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: combinational priority table plus
// multi-cycle sequences for data wait, halt, reset and counter saturation.
module tb_hazard_stall_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_memread, ex_taken;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic       pcWEN, if_W, id_W, ex_W, mem_W, if_flush, id_flush, halt;
  logic [31:0] stall_cnt;
  logic       pcWEN4, if_W4, id_W4, ex_W4, mem_W4, if_flush4, id_flush4, halt4;
  logic [3:0] stall_cnt4;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  localparam logic [7:0] NORM  = 8'b11111000;
  localparam logic [7:0] FRZ   = 8'b00000000;
  localparam logic [7:0] DHIT  = 8'b00111100;
  localparam logic [7:0] TAKEN = 8'b11111110;
  localparam logic [7:0] LU    = 8'b00111010;
  localparam logic [7:0] HLT   = 8'b00000001;

  hazard_stall_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_halt(mem_halt), .ex_memread(ex_memread),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .ex_taken(ex_taken),
    .pcWEN(pcWEN), .if_W(if_W), .id_W(id_W), .ex_W(ex_W), .mem_W(mem_W),
    .if_flush(if_flush), .id_flush(id_flush), .halt(halt), .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_halt(mem_halt), .ex_memread(ex_memread),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .ex_taken(ex_taken),
    .pcWEN(pcWEN4), .if_W(if_W4), .id_W(id_W4), .ex_W(ex_W4), .mem_W(mem_W4),
    .if_flush(if_flush4), .id_flush(id_flush4), .halt(halt4), .stall_cnt(stall_cnt4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ih, dh, dr, dw, mh, mr;
    logic [4:0] ws, rs, rt;
    logic       tk;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(input logic ih, dh, dr, dw, mr, input logic [4:0] ws, rs, rt,
                              input logic tk, input logic [7:0] exp);
    vec_t v;
    v.ih = ih; v.dh = dh; v.dr = dr; v.dw = dw; v.mh = 1'b0; v.mr = mr;
    v.ws = ws; v.rs = rs; v.rt = rt; v.tk = tk; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {pcWEN, if_W, id_W, ex_W, mem_W, if_flush, id_flush, halt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ihit = v.ih; dhit = v.dh; mem_dREN = v.dr; mem_dWEN = v.dw; mem_halt = v.mh;
    ex_memread = v.mr; ex_wsel = v.ws; id_rs = v.rs; id_rt = v.rt; ex_taken = v.tk;
  endtask

  task automatic clr();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
    ex_memread = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; ex_taken = 1'b0;
  endtask

  // Inputs are set just after a negedge; check outputs, then move to the next negedge.
  task automatic step(input string nm, input logic [7:0] e);
    #1 chk(nm, {24'd0, outs()}, {24'd0, e});
    @(negedge CLK);
  endtask

  initial begin
    tv[0]  = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
    tv[1]  = mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, FRZ);
    tv[2]  = mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, DHIT);
    tv[3]  = mk(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, DHIT);
    tv[4]  = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, TAKEN);
    tv[5]  = mk(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, LU);
    tv[6]  = mk(1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0, LU);
    tv[7]  = mk(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, NORM);
    tv[8]  = mk(1, 0, 0, 0, 1, 5'd5, 5'd6, 5'd4, 0, NORM);
    tv[9]  = mk(1, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5, 0, NORM);
    tv[10] = mk(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1, TAKEN);
    tv[11] = mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, FRZ);
    tv[12] = mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
    tv[13] = mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, DHIT);

    clr();
    RST = 1'b1;
    @(negedge CLK);
    step("reset_outs", FRZ);
    RST = 1'b0;
    chk("reset_cnt", stall_cnt, 32'd0);
    step("post_reset_norm", NORM);
    chk("idle_cnt", stall_cnt, 32'd0);

    for (int i = 0; i < 14; i++) begin
      drive(tv[i]);
      step($sformatf("vec%0d", i), tv[i].exp);
      if (!tv[i].exp[7]) exp_cnt++;
      chk($sformatf("vec%0d_cnt", i), stall_cnt, exp_cnt);
    end

    // Load waits three cycles for dhit, then completes.
    clr(); mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("dwait%0d", i), FRZ);
    dhit = 1'b1;
    step("dwait_done", DHIT);
    exp_cnt += 4;
    clr();
    step("dwait_after", NORM);
    chk("dwait_cnt", stall_cnt, exp_cnt);

    // Halt seen during a data wait must not take effect until after the wait.
    mem_dWEN = 1'b1; mem_halt = 1'b1;
    step("halt_dfrz", FRZ);
    dhit = 1'b1;
    step("halt_dfrz_done", DHIT);
    clr();
    step("halt_not_taken_dw", NORM);
    exp_cnt += 2;

    // Reset in the middle of a data wait returns to RUN.
    mem_dREN = 1'b1;
    step("mid_dwait", FRZ);
    RST = 1'b1; clr();
    step("mid_dwait_rst", FRZ);
    RST = 1'b0; exp_cnt = 0;
    chk("mid_dwait_rst_cnt", stall_cnt, 32'd0);

    // Halt during a fetch freeze is deferred, then retires.
    ihit = 1'b0; mem_halt = 1'b1;
    step("halt_ifrz", FRZ);
    exp_cnt++;
    ihit = 1'b1;
    step("halt_retire", NORM);
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = i[1]; mem_dREN = i[0]; mem_halt = 1'b0;
      step($sformatf("halted%0d", i), HLT);
    end
    chk("halted_cnt", stall_cnt, exp_cnt);

    RST = 1'b1; clr();
    step("halt_rst", FRZ);
    RST = 1'b0;
    step("halt_cleared", NORM);
    chk("halt_rst_cnt", stall_cnt, 32'd0);

    // Long fetch stall: narrow counter saturates, wide one keeps counting.
    ihit = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step("sat_frz", FRZ);
      if (i == 15 || i == 16 || i == 20)
        chk($sformatf("sat4_%0d", i), {28'd0, stall_cnt4}, 32'd15);
    end
    chk("sat32_cnt", stall_cnt, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
